alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters: port 0 (execute stage)
//  and port 1 (branch/address unit). Requesters present operands, op code and tag via
//  valid/ready. Round-robin grant; the winner's operands drive the ALU in the same cycle.
//  The result and flags are registered into a per-port response slot, which is drained
//  via its own valid/ready.
// PARAMETERS
//  DATA_W  32  operand/result width (matches `INST_REG_DATA)
//  OP_W    4   ALU op code width (`ALU_* encodings from defines.v)
//  TAG_W   5   opaque tag returned with result (e.g. rd index)
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       asynchronous reset, active-high
//  req0_valid_i     in   1       port 0 request valid
//  req0_ready_o     out  1       port 0 request accepted this cycle
//  req0_data1_i     in   DATA_W  port 0 operand 1
//  req0_data2_i     in   DATA_W  port 0 operand 2
//  req0_op_i        in   OP_W    port 0 op code
//  req0_tag_i       in   TAG_W   port 0 tag
//  req1_*           -    -       same set for port 1
//  alu_data1_o      out  DATA_W  to ALU operand 1
//  alu_data2_o      out  DATA_W  to ALU operand 2
//  alu_op_code_o    out  OP_W    to ALU op code
//  alu_data_i       in   DATA_W  ALU result (combinational)
//  alu_zero_i/alu_sign_i/alu_ovf_i  in 1  ALU flags
//  rsp0_valid_o     out  1       port 0 response slot full
//  rsp0_ready_i     in   1       port 0 consumer takes response
//  rsp0_data_o      out  DATA_W  registered result
//  rsp0_flags_o     out  3       {ovf,sign,zero} registered
//  rsp0_tag_o       out  TAG_W   registered tag
//  rsp1_*           -    -       same set for port 1
// BEHAVIOUR
//  Reset (async, rst=1): rsp*_valid_o=0, rsp*_data/flags/tag=0, last_grant=1 (port 0 wins
//   first tie), ALU inputs driven 0 with op `ALU_ADD. Reset mid-transaction discards the slot.
//  Eligibility: elig_n = reqn_valid_i & (~rspn_valid_o | rspn_ready_i) (slot free or draining).
//  Grant (combinational, one-hot or none):
//   - only one eligible -> grant it.
//   - both eligible -> grant port != last_grant; last_grant <= granted port.
//   - none -> idle; ALU inputs 0/`ALU_ADD; last_grant unchanged.
//  reqn_ready_o = grant_n. Handshake = valid & ready; requester holds fields stable until then.
//  Ready never depends on the other port's rsp slot; a full port 1 slot never blocks port 0.
//  Mux: alu_data1_o/alu_data2_o/alu_op_code_o = granted port's fields.
//  Capture: at edge after handshake on port n, rspn_data<=alu_data_i, flags<={ovf,sign,zero},
//   tag<=reqn_tag_i, rspn_valid_o<=1. Latency request->response = 1 cycle.
//  Drain: rspn_valid_o & rspn_ready_i with no new grant -> rspn_valid_o<=0.
//   Simultaneous drain + grant on same port -> slot reloaded, valid stays 1 (full throughput,
//   one op per cycle per port when consumer always ready; combined max one op per cycle).
//  Response fields hold stable while rspn_valid_o=1 & ~rspn_ready_i.
//  Starvation bound: an eligible requester is granted within 2 cycles.
//  No arithmetic inside the block; widths pass through unchanged.
// TESTING
//  1 Reset: assert rst mid-run -> all rsp*_valid_o=0 immediately; first tie after release grants port 0.
//  2 Single op: port0 ADD 0x7FFFFFFF+1 -> next cycle rsp0_data=0x80000000, flags={1,1,0}, tag echoed.
//  3 Contention: both valid 4 cycles, rsp ready=1 -> grants 0,1,0,1; each rsp 1 cycle after its grant.
//  4 Backpressure: rsp1_ready=0, slot full -> req1_ready=0, port0 SUB 5-7 still completes =0xFFFFFFFE.
//  5 Drain+reload: rsp0 full, rsp0_ready=1 with new port0 req -> rsp0_valid stays 1, data updated.
//  6 Idle: no valid -> ALU inputs 0/`ALU_ADD, no rsp change, last_grant unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a registered valid/ready response slot per port.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned TAG_W  = 5,
    parameter logic [OP_W-1:0] ALU_ADD = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_data1_i,
    input  logic [DATA_W-1:0] req0_data2_i,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [TAG_W-1:0]  req0_tag_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_data1_i,
    input  logic [DATA_W-1:0] req1_data2_i,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [TAG_W-1:0]  req1_tag_i,

    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [OP_W-1:0]   alu_op_code_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_zero_i,
    input  logic              alu_sign_i,
    input  logic              alu_ovf_i,

    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_data_o,
    output logic [2:0]        rsp0_flags_o,
    output logic [TAG_W-1:0]  rsp0_tag_o,

    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_data_o,
    output logic [2:0]        rsp1_flags_o,
    output logic [TAG_W-1:0]  rsp1_tag_o
);

    localparam int unsigned FLAGS_W = 3;

    logic               elig0;
    logic               elig1;
    logic               grant0;
    logic               grant1;
    logic               last_grant;
    logic [FLAGS_W-1:0] alu_flags;

    // A port may bid when its response slot is empty or being drained this cycle.
    assign elig0 = req0_valid_i & (~rsp0_valid_o | rsp0_ready_i);
    assign elig1 = req1_valid_i & (~rsp1_valid_o | rsp1_ready_i);

    // On a tie the port that did not win last time gets the ALU.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Winner's operands drive the ALU; idle cycles present a harmless zero add.
    always_comb begin
        alu_data1_o   = '0;
        alu_data2_o   = '0;
        alu_op_code_o = ALU_ADD;
        if (grant0) begin
            alu_data1_o   = req0_data1_i;
            alu_data2_o   = req0_data2_i;
            alu_op_code_o = req0_op_i;
        end else if (grant1) begin
            alu_data1_o   = req1_data1_i;
            alu_data2_o   = req1_data2_i;
            alu_op_code_o = req1_op_i;
        end
    end

    assign alu_flags = {alu_ovf_i, alu_sign_i, alu_zero_i};

    // Round-robin pointer; resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Port 0 response slot: a grant reloads it even while it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_o <= 1'b0;
            rsp0_data_o  <= '0;
            rsp0_flags_o <= '0;
            rsp0_tag_o   <= '0;
        end else if (grant0) begin
            rsp0_valid_o <= 1'b1;
            rsp0_data_o  <= alu_data_i;
            rsp0_flags_o <= alu_flags;
            rsp0_tag_o   <= req0_tag_i;
        end else if (rsp0_ready_i) begin
            rsp0_valid_o <= 1'b0;
        end
    end

    // Port 1 response slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp1_valid_o <= 1'b0;
            rsp1_data_o  <= '0;
            rsp1_flags_o <= '0;
            rsp1_tag_o   <= '0;
        end else if (grant1) begin
            rsp1_valid_o <= 1'b1;
            rsp1_data_o  <= alu_data_i;
            rsp1_flags_o <= alu_flags;
            rsp1_tag_o   <= req1_tag_i;
        end else if (rsp1_ready_i) begin
            rsp1_valid_o <= 1'b0;
        end
    end

endmodule
